// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// Covers state, opcode/funct, ALU control and mux-select values.
package mc_pkg;

  // Separate lw/sw address states let MEMADR route onward without re-reading the opcode.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdrLw = 4'd2,
    StMemAdrSw = 4'd3,
    StMemRd    = 4'd4,
    StMemWb    = 4'd5,
    StMemWr    = 4'd6,
    StExecute  = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StAddiEx   = 4'd10,
    StAddiWb   = 4'd11,
    StJump     = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] SrcbB     = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU control decoder; valid flags supported funct codes.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = AluAdd;
    valid      = 1'b1;
    case (funct)
      FnAdd:   alucontrol = AluAdd;
      FnSub:   alucontrol = AluSub;
      FnAnd:   alucontrol = AluAnd;
      FnOr:    alucontrol = AluOr;
      FnSlt:   alucontrol = AluSlt;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM: one state register, outputs decoded from state
// (plus mem_ready for the fetch/store handshake strobes).
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [2:0] funct_ctrl;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .alucontrol (funct_ctrl),
    .valid      (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw:    state_d = StMemAdrLw;
          OpSw:    state_d = StMemAdrSw;
          OpRtype: state_d = StExecute;
          OpBeq:   state_d = StBranch;
          OpAddi:  state_d = StAddiEx;
          OpJ:     state_d = StJump;
          default: state_d = StFetch;
        endcase
      end
      StMemAdrLw: state_d = StMemRd;
      StMemAdrSw: state_d = StMemWr;
      StMemRd:    state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:    state_d = mem_ready ? StFetch : StMemWr;
      StExecute:  state_d = funct_valid ? StAluWb : StFetch;
      StAddiEx:   state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    alusrca    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrcb    = SrcbB;
    pcsrc      = PcAlu;
    alucontrol = AluAdd;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb = SrcbFour;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      StDecode: begin
        alusrcb = SrcbImmSh;
        illegal = !op_supported(opcode);
      end
      StMemAdrLw, StMemAdrSw: begin
        alusrca = 1'b1;
        alusrcb = SrcbImm;
      end
      StMemRd:  iord = 1'b1;
      StMemWb: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
      end
      StExecute: begin
        alusrca    = 1'b1;
        alucontrol = funct_ctrl;
        illegal    = !funct_valid;
      end
      StAluWb: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alusrca    = 1'b1;
        alucontrol = AluSub;
        branch     = 1'b1;
        pcsrc      = PcAluOut;
        instr_done = 1'b1;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = SrcbImm;
      end
      StAddiWb: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        pcsrc      = PcJump;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset gates every write/event strobe immediately, not just after the edge.
    if (!rst_n) begin
      pcwrite    = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against a per-instruction step-list reference model.
module tb_multicycle_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       iord, memwrite, irwrite, pcwrite, branch, alusrca, regdst, memtoreg, regwrite;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal, instr_done;
  logic [3:0] state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .alusrca    (alusrca),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .instr_done (instr_done),
    .state      (state)
  );

  typedef struct {
    state_e st;
    logic   rdy;
  } ent_t;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic rdy, input logic [5:0] op, input logic [5:0] fn);
    mem_ready = rdy;
    opcode    = op;
    funct     = fn;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] ref_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      apply(1'b1, 6'($urandom), 6'($urandom));
      n_vec++;
      if ({pcwrite, irwrite, memwrite, regwrite, illegal, instr_done} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_strobes cyc%0d: got %b want 000000", i,
                 {pcwrite, irwrite, memwrite, regwrite, illegal, instr_done});
      end
    end
    rst_n = 1'b1;
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, irwrite} !== {4'(StFetch), 1'b1}) begin
      n_bad++;
      $display("FAIL reset_release: got state %0d irwrite %b want 0/1", state, irwrite);
    end
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if (state !== 4'(StDecode)) begin
      n_bad++;
      $display("FAIL reset_to_decode: got %0d want %0d", state, StDecode);
    end
  endtask

  task automatic test_lw();
    state_e exp_st [5] = '{StFetch, StDecode, StMemAdrLw, StMemRd, StMemWb};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, (i == 1) ? 6'b100011 : 6'($urandom), 6'($urandom));
      n_vec++;
      if (state !== 4'(exp_st[i])) begin
        n_bad++;
        $display("FAIL lw_state cyc%0d: got %0d want %0d", i, state, exp_st[i]);
      end
      n_vec++;
      if ({regwrite, memtoreg, instr_done} !== ((i == 4) ? 3'b111 : 3'b000)) begin
        n_bad++;
        $display("FAIL lw_wb cyc%0d: got %b want %b", i, {regwrite, memtoreg, instr_done},
                 (i == 4) ? 3'b111 : 3'b000);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw_stall();
    state_e exp_st [7] = '{StFetch, StDecode, StMemAdrSw, StMemWr, StMemWr, StMemWr, StMemWr};
    logic   rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(rdy[i], (i == 1) ? 6'b101011 : 6'($urandom), 6'($urandom));
      n_vec++;
      if (state !== 4'(exp_st[i])) begin
        n_bad++;
        $display("FAIL sw_state cyc%0d: got %0d want %0d", i, state, exp_st[i]);
      end
      n_vec++;
      if ({memwrite, instr_done, iord} !== {(i >= 3), (i == 6), (i >= 3)}) begin
        n_bad++;
        $display("FAIL sw_strobes cyc%0d: got %b want %b", i, {memwrite, instr_done, iord},
                 {(i >= 3), (i == 6), (i >= 3)});
      end
      next_cycle();
    end
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, memwrite} !== {4'(StFetch), 1'b0}) begin
      n_bad++;
      $display("FAIL sw_after: got state %0d memwrite %b want 0/0", state, memwrite);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b1, 6'b000000, 6'($urandom));
    next_cycle();
    apply(1'b1, 6'($urandom), 6'b101010);
    n_vec++;
    if ({state, alucontrol, alusrca, alusrcb} !== {4'(StExecute), 3'b111, 1'b1, 2'b00}) begin
      n_bad++;
      $display("FAIL rtype_exec: got st %0d alu %b srca %b srcb %b want 7/111/1/00",
               state, alucontrol, alusrca, alusrcb);
    end
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, regwrite, regdst, memtoreg, instr_done} !== {4'(StAluWb), 4'b1101}) begin
      n_bad++;
      $display("FAIL rtype_wb: got st %0d rw/rd/m2r/done %b want 8/1101",
               state, {regwrite, regdst, memtoreg, instr_done});
    end
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b1, 6'b000000, 6'($urandom));
    next_cycle();
    apply(1'b1, 6'($urandom), 6'b000111);
    n_vec++;
    if ({state, illegal, regwrite, instr_done} !== {4'(StExecute), 3'b100}) begin
      n_bad++;
      $display("FAIL rtype_illegal: got st %0d ill/rw/done %b want 7/100",
               state, {illegal, regwrite, instr_done});
    end
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, regwrite, illegal} !== {4'(StFetch), 2'b00}) begin
      n_bad++;
      $display("FAIL rtype_illegal_next: got st %0d rw/ill %b want 0/00",
               state, {regwrite, illegal});
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b1, 6'b000100, 6'($urandom));
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, alucontrol, branch, pcsrc, instr_done, pcwrite} !==
        {4'(StBranch), 3'b110, 1'b1, 2'b01, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL beq: got st %0d alu %b br %b pcsrc %b done %b pcw %b want 9/110/1/01/1/0",
               state, alucontrol, branch, pcsrc, instr_done, pcwrite);
    end
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b1, 6'b000010, 6'($urandom));
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, pcsrc, pcwrite, instr_done, branch} !==
        {4'(StJump), 2'b10, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL jump: got st %0d pcsrc %b pcw %b done %b br %b want 12/10/1/1/0",
               state, pcsrc, pcwrite, instr_done, branch);
    end
    next_cycle();
    apply(1'b0, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, irwrite} !== {4'(StFetch), 1'b0}) begin
      n_bad++;
      $display("FAIL jump_next: got st %0d irwrite %b want 0/0", state, irwrite);
    end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b1, 6'b100011, 6'($urandom));
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b0, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b0, 6'($urandom), 6'($urandom));
    n_vec++;
    if (state !== 4'(StMemRd)) begin
      n_bad++;
      $display("FAIL lw_stall_state: got %0d want %0d", state, StMemRd);
    end
    rst_n = 1'b0;
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({regwrite, memwrite, pcwrite, irwrite, instr_done} !== 5'b0) begin
      n_bad++;
      $display("FAIL rd_abort_strobes: got %b want 00000",
               {regwrite, memwrite, pcwrite, irwrite, instr_done});
    end
    next_cycle();
    rst_n = 1'b1;
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, regwrite, irwrite} !== {4'(StFetch), 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL rd_abort_next: got st %0d rw %b ir %b want 0/0/1", state, regwrite, irwrite);
    end
    next_cycle();
    apply(1'b1, 6'b101011, 6'($urandom));
    next_cycle();
    apply(1'b1, 6'($urandom), 6'($urandom));
    next_cycle();
    apply(1'b0, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, memwrite} !== {4'(StMemWr), 1'b1}) begin
      n_bad++;
      $display("FAIL sw_stall_pre: got st %0d memwrite %b want 6/1", state, memwrite);
    end
    rst_n = 1'b0;
    apply(1'b1, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({memwrite, instr_done} !== 2'b00) begin
      n_bad++;
      $display("FAIL wr_abort_strobes: got %b want 00", {memwrite, instr_done});
    end
    next_cycle();
    rst_n = 1'b1;
    apply(1'b0, 6'($urandom), 6'($urandom));
    n_vec++;
    if ({state, memwrite} !== {4'(StFetch), 1'b0}) begin
      n_bad++;
      $display("FAIL wr_abort_next: got st %0d memwrite %b want 0/0", state, memwrite);
    end
  endtask

  task automatic test_random();
    ent_t       q[$];
    logic [5:0] op, fn;
    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bit         bad, last, fire;
    int         kind, fw, mw;
    logic [2:0] exp_alu;
    logic [12:0] exp_v, got_v;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      q.delete();
      kind = int'($urandom_range(0, 7));
      fw   = int'($urandom_range(0, 2));
      mw   = int'($urandom_range(0, 3));
      bad  = 1'b0;
      fn   = 6'($urandom);
      op   = 6'b000000;
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: fn = legal_fn[$urandom_range(0, 4)];
        3: begin
          do fn = 6'($urandom);
          while (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
          bad = 1'b1;
        end
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        default: begin
          do op = 6'($urandom);
          while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
          bad = 1'b1;
        end
      endcase
      repeat (fw) q.push_back('{StFetch, 1'b0});
      q.push_back('{StFetch, 1'b1});
      q.push_back('{StDecode, 1'($urandom)});
      case (kind)
        0: begin
          q.push_back('{StMemAdrLw, 1'($urandom)});
          repeat (mw) q.push_back('{StMemRd, 1'b0});
          q.push_back('{StMemRd, 1'b1});
          q.push_back('{StMemWb, 1'($urandom)});
        end
        1: begin
          q.push_back('{StMemAdrSw, 1'($urandom)});
          repeat (mw) q.push_back('{StMemWr, 1'b0});
          q.push_back('{StMemWr, 1'b1});
        end
        2: begin
          q.push_back('{StExecute, 1'($urandom)});
          q.push_back('{StAluWb, 1'($urandom)});
        end
        3: q.push_back('{StExecute, 1'($urandom)});
        4: q.push_back('{StBranch, 1'($urandom)});
        5: begin
          q.push_back('{StAddiEx, 1'($urandom)});
          q.push_back('{StAddiWb, 1'($urandom)});
        end
        6: q.push_back('{StJump, 1'($urandom)});
        default: ;
      endcase
      foreach (q[i]) begin
        last = (i == q.size() - 1);
        apply(q[i].rdy, (q[i].st == StDecode) ? op : 6'($urandom),
              (q[i].st == StExecute) ? fn : 6'($urandom));
        exp_alu = (q[i].st == StExecute) ? ref_alu(fn) :
                  (q[i].st == StBranch)  ? 3'b110 : 3'b010;
        fire  = (q[i].st == StFetch) && q[i].rdy;
        exp_v = {4'(q[i].st), fire, fire || (q[i].st == StJump), (q[i].st == StMemWr),
                 (q[i].st inside {StMemWb, StAluWb, StAddiWb}), last && bad, last && !bad,
                 exp_alu};
        got_v = {state, irwrite, pcwrite, memwrite, regwrite, illegal, instr_done, alucontrol};
        n_vec++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL rand instr%0d kind%0d step%0d: got %h want %h",
                   n, kind, i, got_v, exp_v);
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_branch_jump();
    test_reset_midstall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
